serial_addsub: RTL and testbench

Bit-serial WIDTH-bit adder/subtractor for the MiniGPU arithmetic path. It processes one bit per clock, LSB first, through a single one-bit full-adder cell and a carry flip-flop. Subtraction is performed as a + ~b + 1. Operands enter and results leave through valid/ready handshakes, so the block can sit between an operand-issue stage and the result writeback without extra buffering.

---
 rtl/addsub_pkg.sv | 6 +
 rtl/fulladder.sv | 12 +
 rtl/serial_addsub.sv | 85 ++++++++
 tb/tb_serial_addsub.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// addsub_pkg: shared state encoding and opcode values for serial_addsub
package addsub_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/fulladder.sv
// fulladder: one-bit full-adder cell
// Ports: a, b, cin in; sum, cout out
module fulladder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial WIDTH-bit adder/subtractor, LSB first, valid/ready on both sides
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready with op, a, b;
//        out_valid/out_ready with result, carry_out, overflow, zero
module serial_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);
    localparam int CW = $clog2(WIDTH);
    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, res_q, res_d;
    logic [CW-1:0]    cnt_q;
    logic             carry_q, cmsb_q, cout_q, zero_q;
    logic             s, c_next, last, accept;
    fulladder u_fa (
        .a   (a_q[0]),
        .b   (b_q[0]),
        .cin (carry_q),
        .sum (s),
        .cout(c_next)
    );
    assign last   = cnt_q == CW'(WIDTH - 1);
    assign accept = in_valid & in_ready;
    assign res_d  = {s, res_q[WIDTH-1:1]};
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end
    always_comb begin
        state_d = (state_q == IDLE  && in_valid)  ? SHIFT :
                  (state_q == SHIFT && last)      ? DONE  :
                  (state_q == DONE  && out_ready) ? IDLE  : state_q;
    end
    always_comb begin
        in_ready  = state_q == IDLE;
        out_valid = state_q == DONE;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cmsb_q  <= 1'b0;
            cout_q  <= 1'b0;
            zero_q  <= 1'b0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= (op == OP_SUB) ? ~b : b;
            carry_q <= op;
            cnt_q   <= '0;
            res_q   <= '0;
        end else if (state_q == SHIFT) begin
            a_q     <= a_q >> 1;
            b_q     <= b_q >> 1;
            res_q   <= res_d;
            carry_q <= c_next;
            cnt_q   <= last ? cnt_q : cnt_q + CW'(1);
            if (last) begin
                cmsb_q <= carry_q;
                cout_q <= c_next;
                zero_q <= res_d == '0;
            end
        end
    end
    assign result    = res_q;
    assign carry_out = cout_q;
    assign overflow  = cmsb_q ^ cout_q;
    assign zero      = zero_q;
endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: directed self-checking bench for serial_addsub with WIDTH = 8
module tb_serial_addsub;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       op = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] result;
    logic       carry_out, overflow, zero;
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    serial_addsub #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .carry_out(carry_out),
        .overflow (overflow),
        .zero     (zero)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic issue(input logic o, input logic [7:0] x, input logic [7:0] y);
        int lat;
        check("in_ready_before_accept", in_ready, 1);
        in_valid = 1'b1;
        op = o;
        a = x;
        b = y;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, 8);
    endtask
    task automatic expect_out(input string tag, input logic [7:0] r, input logic c, input logic v, input logic z);
        check({tag, "_result"}, result, r);
        check({tag, "_carry"}, carry_out, c);
        check({tag, "_ovf"}, overflow, v);
        check({tag, "_zero"}, zero, z);
    endtask
    task automatic run_op(input string tag, input logic o, input logic [7:0] x, input logic [7:0] y,
                          input logic [7:0] r, input logic c, input logic v, input logic z);
        issue(o, x, y);
        expect_out(tag, r, c, v, z);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_ready_after"}, in_ready, 1);
    endtask
    typedef struct packed {
        logic       o;
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] r;
        logic       c;
        logic       v;
    } vec_t;
    vec_t stream [4];
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
    initial begin
        stream[0] = '{1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
        stream[1] = '{1'b1, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0};
        stream[2] = '{1'b0, 8'hC8, 8'h64, 8'h2C, 1'b1, 1'b0};
        stream[3] = '{1'b1, 8'h7F, 8'h80, 8'hFF, 1'b0, 1'b1};
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        expect_out("rst", 8'h00, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        run_op("add_3c_45", 1'b0, 8'h3C, 8'h45, 8'h81, 1'b0, 1'b1, 1'b0);
        run_op("sub_10_01", 1'b1, 8'h10, 8'h01, 8'h0F, 1'b1, 1'b0, 1'b0);
        run_op("sub_00_01", 1'b1, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b0);
        run_op("sub_80_01", 1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b0);
        run_op("add_ff_01", 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1);
        issue(1'b0, 8'h12, 8'h34);
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0] ? 1'b0 : 1'b1;
            op = 1'b1;
            a = 8'hFF;
            b = 8'hFF;
            @(negedge clk);
            expect_out("bp", 8'h46, 1'b0, 1'b0, 1'b0);
            check("bp_out_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_ready_after", in_ready, 1);
        check("bp_valid_after", out_valid, 0);
        @(negedge clk);
        check("bp_not_accepted", in_ready, 1);
        in_valid = 1'b1;
        op = 1'b0;
        a = 8'h55;
        b = 8'h22;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        expect_out("midrst", 8'h00, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        run_op("add_01_01", 1'b0, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b1;
        begin
            int prev;
            for (int k = 0; k < 4; k++) begin
                if (k > 0) @(negedge clk);
                issue(stream[k].o, stream[k].x, stream[k].y);
                expect_out($sformatf("stream%0d", k), stream[k].r, stream[k].c, stream[k].v, stream[k].r == 8'h00);
                if (k > 0) check($sformatf("stream%0d_spacing", k), cyc - prev, 10);
                prev = cyc;
            end
        end
        @(negedge clk);
        out_ready = 1'b0;
        check("stream_end_ready", in_ready, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
